// File: rtl/sop_array_cfg.sv
`default_nettype none
// ============================================================================
// sop_array_cfg : run-time programmable AND-OR array, serial shadow config
// Rev 1.0
// ============================================================================
module sop_array_cfg #(
  parameter int NUM_IN    = 6,
  parameter int NUM_TERMS = 4,
  parameter int NUM_OUT   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IN-1:0]  in_data,
  input  logic               cfg_shift,
  input  logic               cfg_din,
  input  logic               cfg_commit,
  output logic               cfg_dout,
  output logic               cfg_ready,
  output logic               cfg_err,
  output logic               cfg_active,
  output logic [NUM_OUT-1:0] out_y
);

  localparam int TERM_W   = 2 * NUM_IN;
  localparam int OUT_W    = NUM_TERMS + 2;
  localparam int OUT_BASE = NUM_TERMS * TERM_W;
  localparam int CFG_BITS = OUT_BASE + NUM_OUT * OUT_W;
  localparam int CNT_W    = $clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

  typedef enum logic [1:0] {
    LD_EMPTY   = 2'd0,
    LD_PARTIAL = 2'd1,
    LD_READY   = 2'd2,
    LD_OVER    = 2'd3
  } load_state_e;

  logic [CFG_BITS-1:0]  shadow_q, shadow_d;
  logic [CFG_BITS-1:0]  active_q, active_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cfg_active_q, cfg_active_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [NUM_OUT-1:0]   y_q, y_d;

  load_state_e          load_state;
  logic [NUM_TERMS-1:0] term;
  logic [NUM_OUT-1:0]   sop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= '0;
      active_q     <= '0;
      cnt_q        <= '0;
      cfg_active_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      y_q          <= '0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      cnt_q        <= cnt_d;
      cfg_active_q <= cfg_active_d;
      cfg_err_q    <= cfg_err_d;
      y_q          <= y_d;
    end
  end

  // Load state is a pure function of the shifted-bit count.
  always_comb begin
    load_state = LD_OVER;
    if (cnt_q == '0) begin
      load_state = LD_EMPTY;
    end else if (cnt_q < CNT_FULL) begin
      load_state = LD_PARTIAL;
    end else if (cnt_q == CNT_FULL) begin
      load_state = LD_READY;
    end
  end

  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    cnt_d        = cnt_q;
    cfg_active_d = cfg_active_q;
    cfg_err_d    = 1'b0;
    if (cfg_commit) begin
      // A shift coinciding with a commit is dropped and spoils the commit.
      cnt_d = '0;
      if (load_state == LD_READY && !cfg_shift) begin
        active_d     = shadow_q;
        cfg_active_d = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (cfg_shift) begin
      shadow_d = {shadow_q[CFG_BITS-2:0], cfg_din};
      if (load_state != LD_OVER) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  for (genvar t = 0; t < NUM_TERMS; t++) begin : g_term
    logic [NUM_IN-1:0] en_true;
    logic [NUM_IN-1:0] en_comp;
    assign en_true = active_q[t*TERM_W +: NUM_IN];
    assign en_comp = active_q[t*TERM_W + NUM_IN +: NUM_IN];
    // Empty terms read 0; x & ~x makes a both-polarity term read 0 too.
    assign term[t] = (|(en_true | en_comp))
                   & (&(~en_true | in_data))
                   & (&(~en_comp | ~in_data));
  end

  for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
    logic [NUM_TERMS-1:0] sel;
    logic                 is_reg;
    logic                 inv;
    assign sel      = active_q[OUT_BASE + o*OUT_W +: NUM_TERMS];
    assign is_reg   = active_q[OUT_BASE + o*OUT_W + NUM_TERMS];
    assign inv      = active_q[OUT_BASE + o*OUT_W + NUM_TERMS + 1];
    assign sop[o]   = (|(sel & term)) ^ inv;
    assign out_y[o] = is_reg ? y_q[o] : sop[o];
  end

  // The output flop tracks sop in both modes so a mode switch is never stale.
  assign y_d = sop;

  assign cfg_dout   = shadow_q[CFG_BITS-1];
  assign cfg_ready  = (load_state == LD_READY);
  assign cfg_err    = cfg_err_q;
  assign cfg_active = cfg_active_q;

endmodule
`default_nettype wire

// File: tb/tb_sop_array_cfg.sv
`default_nettype none
// ============================================================================
// tb_sop_array_cfg : directed + randomized check of sop_array_cfg
// Rev 1.0
// ============================================================================
module tb_sop_array_cfg;

  localparam int NUM_IN    = 6;
  localparam int NUM_TERMS = 4;
  localparam int NUM_OUT   = 2;
  localparam int CFG_BITS  = 60;
  localparam int OUT_BASE  = 48;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_IN-1:0] in_data;
  logic              cfg_shift, cfg_din, cfg_commit;
  logic              cfg_dout, cfg_ready, cfg_err, cfg_active;
  logic [NUM_OUT-1:0] out_y;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [CFG_BITS-1:0] m_shadow, m_active;
  int                  m_cnt;
  logic                m_act, m_err;
  logic [NUM_OUT-1:0]  m_q;

  sop_array_cfg #(.NUM_IN(NUM_IN), .NUM_TERMS(NUM_TERMS), .NUM_OUT(NUM_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data),
    .cfg_shift(cfg_shift), .cfg_din(cfg_din), .cfg_commit(cfg_commit),
    .cfg_dout(cfg_dout), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .cfg_active(cfg_active), .out_y(out_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CFG_BITS-1:0] mk_cfg(
    input logic [23:0] tru, input logic [23:0] cmp,
    input logic [3:0] s0, input logic [3:0] s1,
    input logic r0, input logic i0, input logic r1, input logic i1);
    return {i1, r1, s1, i0, r0, s0,
            cmp[23:18], tru[23:18], cmp[17:12], tru[17:12],
            cmp[11:6],  tru[11:6],  cmp[5:0],   tru[5:0]};
  endfunction

  function automatic logic [NUM_OUT-1:0] ref_sop(input logic [CFG_BITS-1:0] cfg,
                                                 input logic [NUM_IN-1:0] x);
    logic [NUM_OUT-1:0] r;
    for (int o = 0; o < NUM_OUT; o++) begin
      logic any_hit = 1'b0;
      for (int t = 0; t < NUM_TERMS; t++) begin
        if (cfg[OUT_BASE + o*6 + t]) begin
          int  lits = 0;
          logic ok = 1'b1;
          for (int i = 0; i < NUM_IN; i++) begin
            if (cfg[t*12 + i])     begin lits++; if (!x[i]) ok = 1'b0; end
            if (cfg[t*12 + 6 + i]) begin lits++; if (x[i])  ok = 1'b0; end
          end
          if (lits > 0 && ok) any_hit = 1'b1;
        end
      end
      r[o] = any_hit ^ cfg[OUT_BASE + o*6 + 5];
    end
    return r;
  endfunction

  function automatic logic [NUM_OUT-1:0] exp_out();
    logic [NUM_OUT-1:0] s = ref_sop(m_active, in_data);
    logic [NUM_OUT-1:0] r;
    for (int o = 0; o < NUM_OUT; o++)
      r[o] = m_active[OUT_BASE + o*6 + 4] ? m_q[o] : s[o];
    return r;
  endfunction

  task automatic m_reset();
    m_shadow = '0; m_active = '0; m_cnt = 0; m_act = 1'b0; m_err = 1'b0; m_q = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    m_q   = ref_sop(m_active, in_data);
    m_err = 1'b0;
    if (cfg_commit) begin
      if (m_cnt == CFG_BITS && !cfg_shift) begin
        m_active = m_shadow;
        m_act    = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      m_cnt = 0;
    end else if (cfg_shift) begin
      m_shadow = {m_shadow[CFG_BITS-2:0], cfg_din};
      if (m_cnt < CFG_BITS + 1) m_cnt++;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    cfg_shift = 1'b1; cfg_din = b;
    tick();
    cfg_shift = 1'b0; cfg_din = 1'b0;
  endtask

  task automatic load_cfg(input logic [CFG_BITS-1:0] cfg);
    for (int i = CFG_BITS - 1; i >= 0; i--) shift_bit(cfg[i]);
  endtask

  task automatic do_commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_y"},      32'(out_y),      32'(exp_out()));
    chk({tag, "_ready"},  32'(cfg_ready),  32'(m_cnt == CFG_BITS));
    chk({tag, "_err"},    32'(cfg_err),    32'(m_err));
    chk({tag, "_active"}, 32'(cfg_active), 32'(m_act));
    chk({tag, "_dout"},   32'(cfg_dout),   32'(m_shadow[CFG_BITS-1]));
  endtask

  function automatic logic [CFG_BITS-1:0] rand_cfg();
    logic [23:0] tru = 24'($urandom & $urandom);
    logic [23:0] cmp = 24'($urandom & $urandom & $urandom);
    logic [3:0]  r   = 4'($urandom);
    return mk_cfg(tru, cmp, 4'($urandom), 4'($urandom), r[0], r[1], r[2], r[3]);
  endfunction

  logic [CFG_BITS-1:0] cfg_a, cfg_b, cfg_c, cfg_r;
  logic [CFG_BITS-1:0] first_pass;
  logic [NUM_OUT-1:0]  y_before;
  logic [NUM_IN-1:0]   pat_in  [4];
  logic [NUM_OUT-1:0]  pat_exp [4];

  initial begin
    cfg_a = mk_cfg({6'b001100, 6'b000011, 6'b111000, 6'b000111}, 24'h0,
                   4'b0011, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
    cfg_b = mk_cfg({6'b001100, 6'b000011, 6'b111000, 6'b000111}, 24'h0,
                   4'b0011, 4'b1100, 1'b1, 1'b1, 1'b0, 1'b0);
    cfg_c = mk_cfg(24'h0, 24'h0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    pat_in  = '{6'b000111, 6'b111000, 6'b001100, 6'b000000};
    pat_exp = '{2'b11,     2'b01,     2'b10,     2'b00};

    // Reset state
    rst_n = 1'b0; in_data = 6'h3F; cfg_shift = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0;
    m_reset();
    #12;
    chk("rst_y",      32'(out_y),      32'd0);
    chk("rst_ready",  32'(cfg_ready),  32'd0);
    chk("rst_active", 32'(cfg_active), 32'd0);
    chk("rst_dout",   32'(cfg_dout),   32'd0);
    chk("rst_err",    32'(cfg_err),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Combinational config A
    for (int i = CFG_BITS - 1; i >= 0; i--) begin
      shift_bit(cfg_a[i]);
      if (i == 1) chk("ready_at_59", 32'(cfg_ready), 32'd0);
    end
    chk("ready_at_60", 32'(cfg_ready), 32'd1);
    do_commit();
    chk("commit_a_err",    32'(cfg_err),    32'd0);
    chk("commit_a_active", 32'(cfg_active), 32'd1);
    chk("commit_a_ready",  32'(cfg_ready),  32'd0);
    for (int k = 0; k < 4; k++) begin
      in_data = pat_in[k];
      #1;
      chk("comb_pat", 32'(out_y), 32'(pat_exp[k]));
      chk("comb_model", 32'(out_y), 32'(exp_out()));
    end

    // Config B: out0 registered and inverted
    load_cfg(cfg_b);
    do_commit();
    in_data = 6'b000111;
    tick();
    chk("reg_inv_hi_in", 32'(out_y[0]), 32'd0);
    in_data = 6'b000000;
    #1;
    chk("reg_inv_latency", 32'(out_y[0]), 32'd0);
    tick();
    chk("reg_inv_lo_in", 32'(out_y[0]), 32'd1);
    check_all("cfg_b");

    // Commit after 59 bits is rejected
    y_before = out_y;
    for (int i = CFG_BITS - 1; i >= 1; i--) shift_bit(cfg_a[i]);
    do_commit();
    chk("c59_err", 32'(cfg_err), 32'd1);
    chk("c59_y",   32'(out_y),   32'(y_before));
    tick();
    chk("c59_err_pulse", 32'(cfg_err), 32'd0);

    // Commit after 61 bits is rejected
    load_cfg(cfg_a);
    shift_bit(1'b0);
    chk("s61_ready", 32'(cfg_ready), 32'd0);
    do_commit();
    chk("c61_err", 32'(cfg_err), 32'd1);
    chk("c61_y",   32'(out_y),   32'b01);
    tick();
    chk("c61_err_pulse", 32'(cfg_err), 32'd0);

    // Shift and commit together with a full load is rejected
    load_cfg(cfg_c);
    chk("c_ready", 32'(cfg_ready), 32'd1);
    cfg_shift = 1'b1; cfg_din = 1'b1; cfg_commit = 1'b1;
    tick();
    cfg_shift = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0;
    chk("sc_err",   32'(cfg_err),   32'd1);
    chk("sc_y",     32'(out_y),     32'b01);
    chk("sc_ready", 32'(cfg_ready), 32'd0);
    check_all("sc");
    load_cfg(cfg_c);
    do_commit();
    in_data = 6'($urandom);
    #1;
    chk("cfg_c_y", 32'(out_y), 32'b11);

    // Daisy chain readback
    first_pass = {$urandom, $urandom};
    for (int i = 0; i < CFG_BITS; i++) shift_bit(first_pass[i]);
    for (int i = 0; i < CFG_BITS; i++) begin
      chk("daisy_dout", 32'(cfg_dout), 32'(first_pass[i]));
      shift_bit(1'b1);
    end

    // Reset in the middle of a load
    for (int i = 0; i < 30; i++) shift_bit(1'b1);
    chk("pre_rst_y",    32'(out_y),    32'b11);
    chk("pre_rst_dout", 32'(cfg_dout), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("mid_rst_y",      32'(out_y),      32'd0);
    chk("mid_rst_dout",   32'(cfg_dout),   32'd0);
    chk("mid_rst_ready",  32'(cfg_ready),  32'd0);
    chk("mid_rst_active", 32'(cfg_active), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = CFG_BITS - 1; i >= 0; i--) begin
      shift_bit(cfg_a[i]);
      if (i == 1) chk("post_rst_ready_59", 32'(cfg_ready), 32'd0);
    end
    do_commit();
    chk("post_rst_err",    32'(cfg_err),    32'd0);
    chk("post_rst_active", 32'(cfg_active), 32'd1);
    in_data = 6'b000111;
    #1;
    chk("post_rst_y", 32'(out_y), 32'b11);

    // Random configurations against the reference model
    for (int n = 0; n < 8; n++) begin
      cfg_r = rand_cfg();
      load_cfg(cfg_r);
      do_commit();
      check_all("rnd_commit");
      for (int k = 0; k < 16; k++) begin
        in_data = 6'($urandom);
        tick();
        check_all("rnd_cfg");
      end
    end

    // Random control noise
    for (int n = 0; n < 300; n++) begin
      cfg_shift  = ($urandom_range(0, 9) < 7);
      cfg_commit = ($urandom_range(0, 29) == 0);
      cfg_din    = 1'($urandom);
      in_data    = 6'($urandom);
      tick();
      check_all("rnd_noise");
    end
    cfg_shift = 1'b0; cfg_commit = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
